// File: rtl/aq_vlsu_st_data_queue_pkg.sv
// -----------------------------------------------------------------------------
// aq_vlsu_st_data_queue_pkg
// Shared configuration for the vector store-data queue: store data width,
// default queue depth and the packed view of one queued beat.
// -----------------------------------------------------------------------------
package aq_vlsu_st_data_queue_pkg;

    // Store data path width and default number of queue entries; these mirror
    // the core-wide configuration values.
    localparam int LSU_DATAW     = 64;
    localparam int DQ_DEPTH_DFLT = 4;

    // One beat as presented at the head of the queue.
    typedef struct packed {
        logic [LSU_DATAW-1:0] data;
        logic                 last;
        logic                 fls;
    } dq_beat_t;

endpackage : aq_vlsu_st_data_queue_pkg

// File: rtl/aq_vlsu_st_data_queue_if.sv
// -----------------------------------------------------------------------------
// aq_vlsu_st_data_queue_if
// Bundle of the handshake/data signals around the store-data queue.
//   push side : vpu_vlsu_wdata_vld/_wdata/_wdata_last/_wdata_fls -> grnt
//   late data : vpu_vlsu_late_vld/_late_data (fills a head entry awaiting data)
//   pop side  : fwd_next <- vlsu_fwd_vld, vlsu_reg_seq_last, vlsu_reg_fls,
//               vlsu_reg_wdata_ready, vlsu_reg_data
// master = environment (VPU + align stage), slave = the queue.
// -----------------------------------------------------------------------------
interface aq_vlsu_st_data_queue_if;
    import aq_vlsu_st_data_queue_pkg::*;

    logic                 vpu_vlsu_wdata_vld;
    logic [LSU_DATAW-1:0] vpu_vlsu_wdata;
    logic                 vpu_vlsu_wdata_last;
    logic                 vpu_vlsu_wdata_fls;
    logic                 vpu_vlsu_late_vld;
    logic [LSU_DATAW-1:0] vpu_vlsu_late_data;
    logic                 vlsu_vpu_wdata_grnt;
    logic                 fwd_next;
    logic                 vlsu_fwd_vld;
    logic                 vlsu_reg_seq_last;
    logic                 vlsu_reg_fls;
    logic                 vlsu_reg_wdata_ready;
    logic [LSU_DATAW-1:0] vlsu_reg_data;

    modport master (
        output vpu_vlsu_wdata_vld, vpu_vlsu_wdata, vpu_vlsu_wdata_last,
               vpu_vlsu_wdata_fls, vpu_vlsu_late_vld, vpu_vlsu_late_data,
               fwd_next,
        input  vlsu_vpu_wdata_grnt, vlsu_fwd_vld, vlsu_reg_seq_last,
               vlsu_reg_fls, vlsu_reg_wdata_ready, vlsu_reg_data
    );

    modport slave (
        input  vpu_vlsu_wdata_vld, vpu_vlsu_wdata, vpu_vlsu_wdata_last,
               vpu_vlsu_wdata_fls, vpu_vlsu_late_vld, vpu_vlsu_late_data,
               fwd_next,
        output vlsu_vpu_wdata_grnt, vlsu_fwd_vld, vlsu_reg_seq_last,
               vlsu_reg_fls, vlsu_reg_wdata_ready, vlsu_reg_data
    );

endinterface : aq_vlsu_st_data_queue_if

// File: rtl/aq_vlsu_st_data_queue_gated_clk_cell.sv
// -----------------------------------------------------------------------------
// gated_clk_cell
// Latch-based integrated clock gate. The enable is captured while clk_in is
// low so clk_out never glitches during the high phase.
//   clk_in             : free-running clock
//   module_en          : block-level force-on (clock gating disabled when 1)
//   local_en           : functional enable for this register group
//   pad_yy_icg_scan_en : scan mode, forces the clock on
//   clk_out            : gated clock
// -----------------------------------------------------------------------------
module gated_clk_cell (
    input  logic clk_in,
    input  logic module_en,
    input  logic local_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic en_lat;

    always_latch begin
        if (!clk_in) begin
            en_lat <= module_en | local_en | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & en_lat;

endmodule : gated_clk_cell

// File: rtl/aq_vlsu_st_data_queue.sv
// -----------------------------------------------------------------------------
// aq_vlsu_st_data_queue
// Vector store-data queue between the VPU and the store align stage.
// Holds DEPTH beats {data, last, fls}. A beat pushed with fls=1 carries no
// valid data yet; its data is delivered later on the late-data port while it
// is at the head. The late data is bypassed to the output the same cycle and
// written into the entry at the next edge.
//   forever_cpuclk      : clock
//   cpurst_b            : async active-low reset
//   cp0_vpu_icg_en      : clock gate force-on
//   pad_yy_icg_scan_en  : scan enable for the clock gates
//   rtu_yy_xx_flush     : synchronous flush, empties the queue
//   vlsu_st_dq_empty    : queue holds no entries
//   dq_if (slave)       : push, late-data and head/pop signals
// -----------------------------------------------------------------------------
module aq_vlsu_st_data_queue
    import aq_vlsu_st_data_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH_DFLT
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    cp0_vpu_icg_en,
    input  logic                    pad_yy_icg_scan_en,
    input  logic                    rtu_yy_xx_flush,
    output logic                    vlsu_st_dq_empty,
    aq_vlsu_st_data_queue_if.slave  dq_if
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PW:0]          head_q, head_d;
    logic [PW:0]          tail_q, tail_d;
    logic [DEPTH-1:0]     last_q, last_d;
    logic [DEPTH-1:0]     fls_q,  fls_d;
    logic [LSU_DATAW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_idx;
    logic [PW-1:0] tail_idx;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          late_hit;
    logic          push_wr;
    logic          late_wr;
    logic          ctrl_clk_en;
    logic          data_clk_en;
    logic          ctrl_clk;
    logic          data_clk;
    dq_beat_t      head_beat;

    assign head_idx = head_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    assign empty = (head_q == tail_q);
    assign full  = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);

    assign push     = dq_if.vpu_vlsu_wdata_vld && !full;
    assign pop      = dq_if.fwd_next && !empty;
    assign late_hit = dq_if.vpu_vlsu_late_vld && !empty && fls_q[head_idx];

    // A popped head leaves the queue, so its late data is not kept.
    assign push_wr = push && !rtu_yy_xx_flush;
    assign late_wr = late_hit && !pop && !rtu_yy_xx_flush;

    // ------------------------------------------------------------------
    // Clock gates
    // ------------------------------------------------------------------
    assign ctrl_clk_en = push || dq_if.fwd_next || dq_if.vpu_vlsu_late_vld
                         || rtu_yy_xx_flush || !empty;
    assign data_clk_en = push || dq_if.vpu_vlsu_late_vld;

    gated_clk_cell u_ctrl_gclk (
        .clk_in             (forever_cpuclk),
        .module_en          (cp0_vpu_icg_en),
        .local_en           (ctrl_clk_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (ctrl_clk)
    );

    gated_clk_cell u_data_gclk (
        .clk_in             (forever_cpuclk),
        .module_en          (cp0_vpu_icg_en),
        .local_en           (data_clk_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (data_clk)
    );

    // ------------------------------------------------------------------
    // Pointer / flag next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        last_d = last_q;
        fls_d  = fls_q;
        if (rtu_yy_xx_flush) begin
            head_d = '0;
            tail_d = '0;
            last_d = '0;
            fls_d  = '0;
        end else begin
            // Push and late write never target the same slot: that would
            // need head==tail index while non-empty, i.e. full, blocking push.
            if (push) begin
                tail_d           = tail_q + PTR_ONE;
                last_d[tail_idx] = dq_if.vpu_vlsu_wdata_last;
                fls_d[tail_idx]  = dq_if.vpu_vlsu_wdata_fls;
            end
            if (late_wr) begin
                fls_d[head_idx] = 1'b0;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            head_q <= '0;
            tail_q <= '0;
            last_q <= '0;
            fls_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            last_q <= last_d;
            fls_q  <= fls_d;
        end
    end

    // Entry data is left unreset; it is only observed behind a valid flag.
    always_ff @(posedge data_clk) begin
        if (push_wr) begin
            data_q[tail_idx] <= dq_if.vpu_vlsu_wdata;
        end
        if (late_wr) begin
            data_q[head_idx] <= dq_if.vpu_vlsu_late_data;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs
    // ------------------------------------------------------------------
    always_comb begin
        head_beat.data = late_hit ? dq_if.vpu_vlsu_late_data : data_q[head_idx];
        head_beat.last = !empty && last_q[head_idx];
        head_beat.fls  = !empty && fls_q[head_idx];
    end

    assign dq_if.vlsu_vpu_wdata_grnt  = !full;
    assign dq_if.vlsu_fwd_vld         = !empty;
    assign dq_if.vlsu_reg_seq_last    = head_beat.last;
    assign dq_if.vlsu_reg_fls         = head_beat.fls;
    assign dq_if.vlsu_reg_wdata_ready = late_hit;
    assign dq_if.vlsu_reg_data        = head_beat.data;
    assign vlsu_st_dq_empty           = empty;

endmodule : aq_vlsu_st_data_queue

// File: tb/tb_aq_vlsu_st_data_queue.sv
module tb_aq_vlsu_st_data_queue;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    logic icg_en = 1'b0;
    logic scan_en = 1'b0;
    logic flush = 1'b0;
    logic dq_empty;
    bit   chk_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    aq_vlsu_st_data_queue_if dq_if ();

    aq_vlsu_st_data_queue #(.DEPTH(DEPTH)) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_b),
        .cp0_vpu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .rtu_yy_xx_flush    (flush),
        .vlsu_st_dq_empty   (dq_empty),
        .dq_if              (dq_if)
    );

    always #5 clk = ~clk;

    // Behavioural model: a plain queue of beats.
    typedef struct {
        logic [63:0] d;
        bit          last;
        bit          fls;
    } beat_t;
    beat_t mq[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state update on each clock edge, from the inputs held at the edge.
    task automatic model_edge();
        bit    emp, ful, pop_ok, push_ok, late_ok;
        beat_t nb;
        emp = (mq.size() == 0);
        ful = (mq.size() == DEPTH);
        if (flush) begin
            mq.delete();
            return;
        end
        pop_ok  = dq_if.fwd_next && !emp;
        push_ok = dq_if.vpu_vlsu_wdata_vld && !ful;
        late_ok = dq_if.vpu_vlsu_late_vld && !emp && mq[0].fls;
        if (pop_ok) begin
            void'(mq.pop_front());
        end else if (late_ok) begin
            mq[0].d   = dq_if.vpu_vlsu_late_data;
            mq[0].fls = 1'b0;
        end
        if (push_ok) begin
            nb.d    = dq_if.vpu_vlsu_wdata;
            nb.last = dq_if.vpu_vlsu_wdata_last;
            nb.fls  = dq_if.vpu_vlsu_wdata_fls;
            mq.push_back(nb);
        end
    endtask

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) mq.delete();
        else        model_edge();
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit emp, rdy;
        if (rst_b && chk_en) begin
            emp = (mq.size() == 0);
            rdy = dq_if.vpu_vlsu_late_vld && !emp && mq[0].fls;
            check("empty",    dq_empty,                  emp);
            check("fwd_vld",  dq_if.vlsu_fwd_vld,        !emp);
            check("grnt",     dq_if.vlsu_vpu_wdata_grnt, mq.size() != DEPTH);
            check("ready",    dq_if.vlsu_reg_wdata_ready, rdy);
            check("seq_last", dq_if.vlsu_reg_seq_last,   emp ? 1'b0 : mq[0].last);
            check("fls",      dq_if.vlsu_reg_fls,        emp ? 1'b0 : mq[0].fls);
            if (!emp) begin
                check("data", dq_if.vlsu_reg_data, rdy ? dq_if.vpu_vlsu_late_data : mq[0].d);
            end
        end
    end

    // One cycle of stimulus: inputs change just after the rising edge,
    // the task returns just after the following falling edge.
    task automatic step(input bit v, input logic [63:0] d, input bit l, input bit f,
                        input bit fw, input bit lv, input logic [63:0] ld, input bit fl);
        @(posedge clk);
        #1;
        dq_if.vpu_vlsu_wdata_vld  = v;
        dq_if.vpu_vlsu_wdata      = d;
        dq_if.vpu_vlsu_wdata_last = l;
        dq_if.vpu_vlsu_wdata_fls  = f;
        dq_if.fwd_next            = fw;
        dq_if.vpu_vlsu_late_vld   = lv;
        dq_if.vpu_vlsu_late_data  = ld;
        flush                     = fl;
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 64'h0, 0, 0, 0, 0, 64'h0, 0);
    endtask

    task automatic push(input logic [63:0] d, input bit l, input bit f);
        step(1, d, l, f, 0, 0, 64'h0, 0);
    endtask

    task automatic pop();
        step(0, 64'h0, 0, 0, 1, 0, 64'h0, 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_fwd_vld"}, dq_if.vlsu_fwd_vld, 1'b0);
        check({tag, "_empty"},   dq_empty, 1'b1);
        check({tag, "_grnt"},    dq_if.vlsu_vpu_wdata_grnt, 1'b1);
        check({tag, "_ready"},   dq_if.vlsu_reg_wdata_ready, 1'b0);
        check({tag, "_last"},    dq_if.vlsu_reg_seq_last, 1'b0);
        check({tag, "_fls"},     dq_if.vlsu_reg_fls, 1'b0);
    endtask

    initial begin
        logic [63:0] exp_d;
        dq_if.vpu_vlsu_wdata_vld  = 0;
        dq_if.vpu_vlsu_wdata      = '0;
        dq_if.vpu_vlsu_wdata_last = 0;
        dq_if.vpu_vlsu_wdata_fls  = 0;
        dq_if.fwd_next            = 0;
        dq_if.vpu_vlsu_late_vld   = 0;
        dq_if.vpu_vlsu_late_data  = '0;

        #3;
        reset_checks("rst0");
        repeat (2) @(negedge clk);
        #2;
        rst_b  = 1'b1;
        chk_en = 1'b1;

        // Fill to full, then drain in order.
        push(64'h11, 0, 0);
        push(64'h22, 0, 0);
        push(64'h33, 0, 0);
        push(64'h44, 1, 0);
        idle();
        check("fill_grnt", dq_if.vlsu_vpu_wdata_grnt, 1'b0);
        check("fill_head", dq_if.vlsu_reg_data, 64'h11);
        for (int i = 0; i < 4; i++) begin
            pop();
            exp_d = 64'h11 * (i + 1);
            check("drain_data", dq_if.vlsu_reg_data, exp_d);
            check("drain_last", dq_if.vlsu_reg_seq_last, (i == 3));
        end
        idle();
        check("drain_empty", dq_empty, 1'b1);

        // Full queue: push and pop together, push is refused.
        for (int i = 1; i <= 4; i++) push(64'hA0 + 64'(i), 0, 0);
        step(1, 64'h99, 0, 0, 1, 0, 64'h0, 0);
        check("fullpp_grnt", dq_if.vlsu_vpu_wdata_grnt, 1'b0);
        check("fullpp_head", dq_if.vlsu_reg_data, 64'hA1);
        idle();
        check("fullpp_grnt_after", dq_if.vlsu_vpu_wdata_grnt, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            pop();
            exp_d = 64'hA0 + 64'(i);
            check("fullpp_drain", dq_if.vlsu_reg_data, exp_d);
        end
        idle();
        check("fullpp_empty", dq_empty, 1'b1);

        // Deferred-data beat filled by late data.
        push(64'h5555, 1, 1);
        step(0, 64'h0, 0, 0, 0, 1, 64'hDEAD, 0);
        check("late_bypass", dq_if.vlsu_reg_data, 64'hDEAD);
        check("late_ready",  dq_if.vlsu_reg_wdata_ready, 1'b1);
        idle();
        check("late_fls",   dq_if.vlsu_reg_fls, 1'b0);
        check("late_data",  dq_if.vlsu_reg_data, 64'hDEAD);
        check("late_rdy0",  dq_if.vlsu_reg_wdata_ready, 1'b0);
        pop();
        idle();

        // Flush overrides a simultaneous push and pop.
        push(64'h1, 0, 0);
        push(64'h2, 0, 0);
        step(1, 64'h3, 0, 0, 1, 0, 64'h0, 1);
        idle();
        check("flush_empty", dq_empty, 1'b1);
        check("flush_fwd",   dq_if.vlsu_fwd_vld, 1'b0);
        check("flush_grnt",  dq_if.vlsu_vpu_wdata_grnt, 1'b1);

        // Streaming push+pop across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(1, 64'h100 + 64'(i), 0, 0, 1, 0, 64'h0, 0);
            check("stream_grnt", dq_if.vlsu_vpu_wdata_grnt, 1'b1);
        end
        pop();
        check("stream_tail", dq_if.vlsu_reg_data, 64'h113);
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 3), $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 3), {$urandom, $urandom},
                 ($urandom_range(0, 99) < 3));
        end

        // Asynchronous reset with entries present.
        step(0, 64'h0, 0, 0, 0, 0, 64'h0, 1);
        push(64'hBEEF, 1, 1);
        push(64'h2, 0, 0);
        push(64'h3, 0, 0);
        idle();
        check("prerst_fls", dq_if.vlsu_reg_fls, 1'b1);
        dq_if.vpu_vlsu_late_vld  = 1'b1;
        dq_if.vpu_vlsu_late_data = 64'hCAFE;
        rst_b = 1'b0;
        #1;
        reset_checks("rst1");
        dq_if.vpu_vlsu_late_vld = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_b = 1'b1;
        idle();
        check("postrst_empty", dq_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_aq_vlsu_st_data_queue
